// File: rtl/mux_nx1_sched_pkg.sv
// Shared types and helpers for the registered N:1 scheduling multiplexer.
// Channel mode encoding and a one-hot decoder usable at any channel count up to MAX_N.
package mux_sched_pkg;

   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;

   localparam int unsigned MAX_N = 64;

   // Callers take the low N bits of the result.
   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
      return MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_nx1_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins.
// grant is one-hot, or zero when no request is present.
module rr_arbiter
   import mux_sched_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx
);

   logic [SW-1:0]    idx;
   logic             found;
   logic [MAX_N-1:0] oh;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      found     = 1'b0;
      oh        = '0;
      // Walk offsets from farthest to nearest so the nearest requester is the final winner.
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr + SW'(k);
         if (req[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
      end
      oh = onehot({{(32 - SW){1'b0}}, grant_idx});
      if (found) begin
         grant = oh[N-1:0];
      end
   end

endmodule

// File: rtl/mux_nx1_sched.sv
// Registered N:1 multiplexer with valid/ready on every port, in fixed-select or round-robin mode.
// The output register is refilled in the same cycle it drains, giving one word per cycle.
module mux_nx1_sched
   import mux_sched_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 1,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [W-1:0]     out_data_q;
   logic [SW-1:0]    out_ch_q;
   logic             out_valid_q;
   logic [SW-1:0]    ptr_q;

   logic             load;
   logic             rr_mode;
   logic [N-1:0]     rr_grant;
   logic [SW-1:0]    rr_idx;
   logic [N-1:0]     fix_grant;
   logic [MAX_N-1:0] sel_oh;
   logic [N-1:0]     grant;
   logic [SW-1:0]    grant_idx;
   logic             any_grant;
   logic [W-1:0]     grant_data;

   rr_arbiter #(
      .N (N)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   assign rr_mode = (mode_e'(mode) == MODE_RR);
   assign load    = !out_valid_q || out_ready;

   always_comb begin
      sel_oh     = onehot({{(32 - SW){1'b0}}, sel});
      fix_grant  = in_valid[sel] ? sel_oh[N-1:0] : '0;
      grant      = rr_mode ? rr_grant : fix_grant;
      grant_idx  = rr_mode ? rr_idx : sel;
      any_grant  = |grant;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SW'(i)) begin
            grant_data = in_data[i*W +: W];
         end
      end
      // No transfer may be reported while reset is discarding the output register.
      in_ready = rst ? '0 : (grant & {N{load}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else if (load) begin
         if (any_grant) begin
            out_data_q  <= grant_data;
            out_ch_q    <= grant_idx;
            out_valid_q <= 1'b1;
            if (rr_mode) begin
               ptr_q <= grant_idx + SW'(1);
            end
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_sched.sv
// Directed bench for mux_nx1_sched: an 8x1-bit instance and a 4x16-bit instance.
module tb_mux_nx1_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 8-channel, 1-bit instance
   logic        rst8;
   logic [7:0]  in_data8;
   logic [7:0]  in_valid8;
   logic [7:0]  in_ready8;
   logic        mode8;
   logic [2:0]  sel8;
   logic        out_data8;
   logic [2:0]  out_ch8;
   logic        out_valid8;
   logic        out_ready8;

   // 4-channel, 16-bit instance
   logic        rst4;
   logic [63:0] in_data4;
   logic [3:0]  in_valid4;
   logic [3:0]  in_ready4;
   logic        mode4;
   logic [1:0]  sel4;
   logic [15:0] out_data4;
   logic [1:0]  out_ch4;
   logic        out_valid4;
   logic        out_ready4;

   mux_nx1_sched #(.N(8), .W(1)) u_d8 (
      .clk       (clk),
      .rst       (rst8),
      .in_data   (in_data8),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .mode      (mode8),
      .sel       (sel8),
      .out_data  (out_data8),
      .out_ch    (out_ch8),
      .out_valid (out_valid8),
      .out_ready (out_ready8)
   );

   mux_nx1_sched #(.N(4), .W(16)) u_d4 (
      .clk       (clk),
      .rst       (rst4),
      .in_data   (in_data4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .mode      (mode4),
      .sel       (sel4),
      .out_data  (out_data4),
      .out_ch    (out_ch4),
      .out_valid (out_valid4),
      .out_ready (out_ready4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_ch;
      logic [7:0] pat;

      rst8 = 1'b1; mode8 = 1'b0; sel8 = 3'd5; in_valid8 = 8'hFF; in_data8 = 8'h20;
      out_ready8 = 1'b1;
      rst4 = 1'b1; mode4 = 1'b1; sel4 = 2'd0; in_valid4 = 4'hF;
      in_data4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; out_ready4 = 1'b1;

      // Reset and basic fixed select
      #1;
      chk("rst_in_ready", 64'(in_ready8), 64'h0);
      step();
      rst8 = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid8), 64'h0);
      chk("rst_out_ch", 64'(out_ch8), 64'h0);
      chk("rst_out_data", 64'(out_data8), 64'h0);
      chk("fix_in_ready", 64'(in_ready8), 64'h20);
      step();
      chk("fix_out_data", 64'(out_data8), 64'h1);
      chk("fix_out_ch", 64'(out_ch8), 64'd5);
      chk("fix_out_valid", 64'(out_valid8), 64'h1);

      // Fixed mode with the selected channel idle
      sel8 = 3'd3; in_valid8 = 8'hF7;
      #1;
      chk("idle_in_ready", 64'(in_ready8), 64'h0);
      step();
      chk("idle_out_valid", 64'(out_valid8), 64'h0);
      chk("idle_ch_hold", 64'(out_ch8), 64'd5);
      chk("fix_ptr_hold", 64'(u_d8.ptr_q), 64'd0);

      // Round-robin over all eight channels, ptr wraps
      mode8 = 1'b1; in_valid8 = 8'hFF; pat = 8'hA5; in_data8 = pat;
      for (int i = 0; i < 9; i++) begin
         step();
         exp_ch = 3'(i % 8);
         chk("rr_out_ch", 64'(out_ch8), 64'(exp_ch));
         chk("rr_out_data", 64'(out_data8), 64'(pat[exp_ch]));
         if (i == 7) chk("rr_ptr_wrap", 64'(u_d8.ptr_q), 64'd0);
      end
      chk("rr_ptr_after", 64'(u_d8.ptr_q), 64'd1);

      // Sparse requests from ptr=3
      in_valid8 = 8'b0000_0100;
      step();
      chk("sp_setup_ch", 64'(out_ch8), 64'd2);
      chk("sp_setup_ptr", 64'(u_d8.ptr_q), 64'd3);
      in_valid8 = 8'b1000_0100;
      step();
      chk("sp_ch_a", 64'(out_ch8), 64'd7);
      chk("sp_ptr_a", 64'(u_d8.ptr_q), 64'd0);
      step();
      chk("sp_ch_b", 64'(out_ch8), 64'd2);
      step();
      chk("sp_ch_c", 64'(out_ch8), 64'd7);
      chk("sp_data_c", 64'(out_data8), 64'h1);

      // Backpressure: word A = ch7/data 1 held for four cycles
      out_ready8 = 1'b0; in_data8 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_in_ready", 64'(in_ready8), 64'h0);
         step();
         chk("bp_out_data", 64'(out_data8), 64'h1);
         chk("bp_out_ch", 64'(out_ch8), 64'd7);
         chk("bp_out_valid", 64'(out_valid8), 64'h1);
         chk("bp_ptr", 64'(u_d8.ptr_q), 64'd0);
      end
      out_ready8 = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready8), 64'h04);
      step();
      chk("rel_out_ch", 64'(out_ch8), 64'd2);
      chk("rel_out_data", 64'(out_data8), 64'h0);
      chk("rel_out_valid", 64'(out_valid8), 64'h1);

      // Wide instance: reset mid-stall
      rst4 = 1'b0;
      step();
      chk("w_ch0", 64'(out_ch4), 64'd0);
      chk("w_data0", 64'(out_data4), 64'h1111);
      step();
      chk("w_ch1", 64'(out_ch4), 64'd1);
      chk("w_data1", 64'(out_data4), 64'h2222);
      out_ready4 = 1'b0;
      step();
      chk("w_stall_data", 64'(out_data4), 64'h2222);
      chk("w_stall_ptr", 64'(u_d4.ptr_q), 64'd2);
      rst4 = 1'b1;
      #1;
      chk("w_rst_in_ready", 64'(in_ready4), 64'h0);
      step();
      rst4 = 1'b0;
      #1;
      chk("w_rst_valid", 64'(out_valid4), 64'h0);
      chk("w_rst_data", 64'(out_data4), 64'h0);
      chk("w_rst_ptr", 64'(u_d4.ptr_q), 64'd0);
      chk("w_rst_grant", 64'(in_ready4), 64'h1);
      step();
      chk("w_first_ch", 64'(out_ch4), 64'd0);
      chk("w_first_data", 64'(out_data4), 64'h1111);
      chk("w_first_valid", 64'(out_valid4), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
